// File: rtl/connect4_board_engine.sv
// Connect-4 board engine: stores the board, accepts drops for the player to move and runs a
// fixed-length 24-cycle line scan around the newest piece, followed by a one-cycle report.
// Optional display read port enabled by defining CONNECT4_READ_PORT_EN.
module connect4_board_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic       drop,
  input  logic [2:0] column,
  output logic [1:0] in_game_status,
  output logic       invalid_column,
  output logic       player_turn,
  output logic       busy,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int TW = $clog2(ROWS * COLS + 1);
  localparam logic [3:0]    RowsL      = 4'(ROWS);
  localparam logic [3:0]    ColsL      = 4'(COLS);
  localparam logic [HW-1:0] HeightFull = HW'(ROWS);
  localparam logic [TW-1:0] CellsAll   = TW'(ROWS * COLS);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e        state_q, state_d;
  logic [1:0]    board_q [ROWS][COLS];
  logic [1:0]    board_d [ROWS][COLS];
  logic [HW-1:0] height_q [COLS];
  logic [HW-1:0] height_d [COLS];
  logic [TW-1:0] total_q, total_d;
  logic [1:0]    status_q, status_d;
  logic          inv_q, inv_d, turn_q, turn_d;
  logic [2:0]    base_r_q, base_r_d, base_c_q, base_c_d;
  logic [1:0]    dir_q, dir_d;
  logic [2:0]    k_q, k_d, run_q, run_d;
  logic          stop_q, stop_d, win_q, win_d;

  logic [1:0]    owner;
  logic [4:0]    br, bc, off, pr, pc;
  logic          fwd, first, on_board, ext, col_ok, eligible;
  logic [2:0]    run_n;
  logic [HW-1:0] col_h;

  // Probe cell for the current scan step; coordinates are 5-bit two's complement so bit 4
  // flags a negative (off-board) position.
  always_comb begin
    owner = turn_q ? 2'b10 : 2'b01;
    br    = {2'b00, base_r_q};
    bc    = {2'b00, base_c_q};
    fwd   = (k_q < 3'd3);
    first = (k_q == 3'd0) || (k_q == 3'd3);
    off   = fwd ? ({2'b00, k_q} + 5'd1) : ({2'b00, k_q} - 5'd2);
    pr    = br;
    pc    = bc;
    case (dir_q)
      2'd0: pc = fwd ? bc + off : bc - off;
      2'd1: pr = fwd ? br + off : br - off;
      2'd2: begin
        pr = fwd ? br + off : br - off;
        pc = fwd ? bc + off : bc - off;
      end
      default: begin
        pr = fwd ? br + off : br - off;
        pc = fwd ? bc - off : bc + off;
      end
    endcase
    on_board = !pr[4] && !pc[4] && (pr[3:0] < RowsL) && (pc[3:0] < ColsL);
    ext      = on_board && (first || !stop_q) &&
               (board_q[pr[RW-1:0]][pc[CW-1:0]] == owner);
    run_n    = ((k_q == 3'd0) ? 3'd0 : run_q) + {2'b00, ext};
    col_ok   = ({1'b0, column} < ColsL);
    col_h    = height_q[column[CW-1:0]];
    eligible = (state_q == StIdle) && drop && (status_q == 2'b00) &&
               (current_state == {turn_q, ~turn_q});
  end

  // Next-state logic for the board, counters and the IDLE/SCAN/REPORT sequencer.
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    height_d = height_q;
    total_d  = total_q;
    status_d = status_q;
    inv_d    = inv_q;
    turn_d   = turn_q;
    base_r_d = base_r_q;
    base_c_d = base_c_q;
    dir_d    = dir_q;
    k_d      = k_q;
    run_d    = run_q;
    stop_d   = stop_q;
    win_d    = win_q;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          if (!col_ok || (col_h == HeightFull)) begin
            inv_d = 1'b1;
          end else begin
            board_d[col_h[RW-1:0]][column[CW-1:0]] = owner;
            height_d[column[CW-1:0]] = col_h + 1'b1;
            total_d  = total_q + 1'b1;
            inv_d    = 1'b0;
            base_r_d = 3'(col_h);
            base_c_d = column;
            dir_d    = 2'd0;
            k_d      = 3'd0;
            run_d    = 3'd0;
            stop_d   = 1'b0;
            win_d    = 1'b0;
            state_d  = StScan;
          end
        end
      end
      StScan: begin
        run_d  = run_n;
        stop_d = !ext;
        if (k_q == 3'd5) begin
          if (run_n >= 3'd3) win_d = 1'b1;
          k_d   = 3'd0;
          dir_d = dir_q + 2'd1;
          if (dir_q == 2'd3) state_d = StReport;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      StReport: begin
        state_d = StIdle;
        if (win_q) begin
          status_d = 2'b01;
        end else if (total_q == CellsAll) begin
          status_d = 2'b10;
        end else begin
          status_d = 2'b00;
          turn_d   = ~turn_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      board_q  <= '{default: '0};
      height_q <= '{default: '0};
      total_q  <= '0;
      status_q <= 2'b00;
      inv_q    <= 1'b0;
      turn_q   <= 1'b0;
      base_r_q <= 3'd0;
      base_c_q <= 3'd0;
      dir_q    <= 2'd0;
      k_q      <= 3'd0;
      run_q    <= 3'd0;
      stop_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      height_q <= height_d;
      total_q  <= total_d;
      status_q <= status_d;
      inv_q    <= inv_d;
      turn_q   <= turn_d;
      base_r_q <= base_r_d;
      base_c_q <= base_c_d;
      dir_q    <= dir_d;
      k_q      <= k_d;
      run_q    <= run_d;
      stop_q   <= stop_d;
      win_q    <= win_d;
    end
  end

  assign in_game_status = status_q;
  assign invalid_column = inv_q;
  assign player_turn    = turn_q;
  assign busy           = (state_q != StIdle);

`ifdef CONNECT4_READ_PORT_EN
  // Display read port; out-of-range coordinates read as empty.
  always_comb begin
    rd_cell = 2'b00;
    if (({1'b0, rd_row} < RowsL) && ({1'b0, rd_col} < ColsL)) begin
      rd_cell = board_q[rd_row[RW-1:0]][rd_col[CW-1:0]];
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_row, rd_col};
  assign rd_cell   = 2'b00;
`endif

endmodule

// File: tb/tb_connect4_board_engine.sv
// Self-checking bench for connect4_board_engine: directed games plus randomized play checked
// against a whole-board reference model.
module tb_connect4_board_engine;
  localparam int ROWS = 6;
  localparam int COLS = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] current_state = 2'b00;
  logic       drop = 1'b0;
  logic [2:0] column = 3'd0;
  logic [2:0] rd_row = 3'd0;
  logic [2:0] rd_col = 3'd0;
  logic [1:0] in_game_status;
  logic       invalid_column;
  logic       player_turn;
  logic       busy;
  logic [1:0] rd_cell;

  connect4_board_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk            (clk),
    .reset          (reset),
    .current_state  (current_state),
    .drop           (drop),
    .column         (column),
    .in_game_status (in_game_status),
    .invalid_column (invalid_column),
    .player_turn    (player_turn),
    .busy           (busy),
    .rd_row         (rd_row),
    .rd_col         (rd_col),
    .rd_cell        (rd_cell)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model
  int mb [ROWS][COLS];
  int mh [COLS];
  int m_total, m_status, m_turn, m_inv;

  int tie_seq [42] = '{0,2,2,0,0,2,2,0,0,2,2,0, 1,3,3,1,1,3,3,1,1,3,3,1,
                       4,6,6,4,4,6,6,4,4,6,6,4, 5,5,5,5,5,5};
  int win_seq [42] = '{1,1,1,1,1,1, 5,5,5,5,5,5, 4,2,2,4,4,4,0,0,4,0,4,0,
                       0,2,0,3,2,2,2,6,3,3,3,3,6,6,6,6,6,3};

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_total++;
    assert (got === 32'(exp)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit has_win(input int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int i = 0; i < 4; i++) begin
            int rr = r + i * dr[d];
            int cc = c + i * dc[d];
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (mb[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [1:0] good_cs();
    return (m_turn != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 0;
    for (int c = 0; c < COLS; c++) mh[c] = 0;
    m_total = 0; m_status = 0; m_turn = 0; m_inv = 0;
  endtask

  task automatic rd_at(input string tag, input int r, input int c);
    int exp;
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
`ifdef CONNECT4_READ_PORT_EN
    exp = (r < ROWS && c < COLS) ? mb[r][c] : 0;
`else
    exp = 0;
`endif
    chk(tag, rd_cell, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_status"}, in_game_status, m_status);
    chk({tag, "_turn"}, player_turn, m_turn);
    chk({tag, "_invalid"}, invalid_column, m_inv);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drop  = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    rd_at("reset_cell", 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One drop request; an accepted drop is followed until its result is reported.
  task automatic mv(input int col, input logic [1:0] cs, input bit noisy);
    bit elig, legal;
    int n;
    elig  = (m_status == 0) && (cs == good_cs());
    legal = elig && (col < COLS);
    if (legal) legal = (mh[col] < ROWS);
    @(negedge clk);
    drop = 1'b1; column = 3'(col); current_state = cs;
    @(negedge clk);
    drop = 1'b0;
    if (legal) begin
      mb[mh[col]][col] = (m_turn != 0) ? 2 : 1;
      mh[col]++;
      m_total++;
      m_inv = 0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        drop   = noisy && ($urandom_range(0, 2) == 0);
        column = 3'($urandom_range(0, 7));
        @(negedge clk);
      end
      drop = 1'b0;
      chk("latency", n, 25);
      if (has_win((m_turn != 0) ? 2 : 1)) m_status = 1;
      else if (m_total == ROWS * COLS) m_status = 2;
      else m_turn ^= 1;
    end else if (elig) begin
      m_inv = 1;
    end
    check_outputs("move");
  endtask

  initial begin
    model_reset();
    do_reset();

    // First move: P1 into column 3
    mv(3, 2'b01, 1'b0);
    chk("first_status", in_game_status, 0);
    chk("first_turn", player_turn, 1);
    rd_at("first_cell", 0, 3);

    // Vertical win for P1 on the 7th drop
    do_reset();
    for (int i = 0; i < 7; i++) mv(i % 2, good_cs(), 1'b0);
    chk("vwin_status", in_game_status, 1);
    chk("vwin_turn", player_turn, 0);
    mv(2, good_cs(), 1'b0);
    chk("hold_status", in_game_status, 1);

    // Full column rejection, then recovery
    do_reset();
    for (int i = 0; i < 6; i++) mv(2, good_cs(), 1'b0);
    mv(2, good_cs(), 1'b0);
    chk("full_invalid", invalid_column, 1);
    chk("full_turn", player_turn, 0);
    mv(3, good_cs(), 1'b0);
    chk("recover_invalid", invalid_column, 0);

    // Out-of-range column, END_GAME state and wrong player are ignored or rejected
    mv(7, good_cs(), 1'b0);
    chk("col7_invalid", invalid_column, 1);
    mv(0, 2'b11, 1'b0);
    chk("endgame_invalid", invalid_column, 1);
    mv(0, 2'b01, 1'b0);
    chk("wrongp_turn", player_turn, 1);

    // Full board without a line -> tie
    do_reset();
    for (int i = 0; i < 42; i++) mv(tie_seq[i], good_cs(), 1'b0);
    chk("tie_status", in_game_status, 2);

    // 42nd piece completes a diagonal -> win beats tie
    do_reset();
    for (int i = 0; i < 42; i++) mv(win_seq[i], good_cs(), 1'b0);
    chk("lastwin_status", in_game_status, 1);

    // Reset in the middle of a scan
    do_reset();
    @(negedge clk);
    drop = 1'b1; column = 3'd4; current_state = 2'b01;
    @(negedge clk);
    drop = 1'b0;
    repeat (9) @(negedge clk);
    chk("midscan_busy", busy, 1);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("abort");
    rd_at("abort_cell", 0, 4);
    @(negedge clk);
    reset = 1'b0;
    mv(0, 2'b01, 1'b0);
    chk("after_abort_turn", player_turn, 1);
    rd_at("after_abort_cell", 0, 0);

    // Randomized games
    for (int g = 0; g < 4; g++) begin
      do_reset();
      for (int k = 0; k < 55; k++) begin
        int rc;
        logic [1:0] rs;
        rc = $urandom_range(0, 7);
        rs = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : good_cs();
        mv(rc, rs, 1'b1);
        rd_at("rand_cell", $urandom_range(0, 7), $urandom_range(0, 7));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
